nn_argmax_reader: RTL and testbench

NN_ARGMAX_READER -- requirements
Module: nn_argmax_reader

---
 rtl/nn_argmax_reader_pkg.sv | 17 +
 rtl/nn_argmax_reader_fp32_gt.sv | 27 ++
 rtl/nn_argmax_reader.sv | 133 +++++++++++++
 tb/tb_nn_argmax_reader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/nn_argmax_reader_pkg.sv
// Shared types and constants for the argmax reader.
// Holds the FSM encoding and the float32 field layout.
package nn_argmax_reader_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;

  localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nn_argmax_reader_fp32_gt.sv
// Combinational float32 a > b with NaN detection.
// Either operand NaN yields gt=0; +0 and -0 compare equal.
module fp32_gt
  import nn_argmax_reader_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt,
  output logic        a_nan
);

  logic        b_nan;
  logic        zeros;
  logic [31:0] ka;
  logic [31:0] kb;

  assign a_nan = (a[MAN_W +: EXP_W] == '1) && (a[MAN_W-1:0] != '0);
  assign b_nan = (b[MAN_W +: EXP_W] == '1) && (b[MAN_W-1:0] != '0);
  assign zeros = (a[30:0] == '0) && (b[30:0] == '0);

  // Map to unsigned keys that sort in numeric order.
  assign ka = a[31] ? ~a : {1'b1, a[30:0]};
  assign kb = b[31] ? ~b : {1'b1, b[30:0]};

  assign gt = !a_nan && !b_nan && !zeros && (ka > kb);

endmodule

// File: rtl/nn_argmax_reader.sv
// Sequential argmax over a float32 vector, one element per cycle.
// Optional NN_ARGMAX_NAN_FLAG_EN adds the nan_seen output.
module nn_argmax_reader
  import nn_argmax_reader_pkg::*;
#(
  parameter int OUT_SIZE = 10,
  parameter int IDX_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [32*OUT_SIZE-1:0]  result,
  input  logic                    start,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        class_idx,
  output logic [31:0]             max_value
`ifdef NN_ARGMAX_NAN_FLAG_EN
  ,
  output logic                    nan_seen
`endif
);

  state_e                  state_q, state_d;
  logic [32*OUT_SIZE-1:0]  snap_q;
  logic [IDX_W-1:0]        cnt_q;
  logic [31:0]             best_q;
  logic [IDX_W-1:0]        best_idx_q;
  logic                    best_vld_q;
  logic [IDX_W-1:0]        idx_q;
  logic [31:0]             max_q;

  logic [31:0] elem;
  logic        cand_gt;
  logic        cand_nan;
  logic        take;
  logic        last;

  assign elem = snap_q[32*cnt_q +: 32];
  assign take = !cand_nan && (!best_vld_q || cand_gt);
  assign last = (cnt_q == IDX_W'(OUT_SIZE-1));

  fp32_gt u_gt (
    .a     (elem),
    .b     (best_q),
    .gt    (cand_gt),
    .a_nan (cand_nan)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)     state_d = ST_SCAN;
      ST_SCAN: if (last)      state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

`ifdef NN_ARGMAX_NAN_FLAG_EN
  logic nan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_q <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      nan_q <= 1'b0;
    end else if (state_q == ST_SCAN) begin
      nan_q <= nan_q | cand_nan;
    end
  end

  assign nan_seen = nan_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q     <= '0;
      cnt_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      best_vld_q <= 1'b0;
      idx_q      <= '0;
      max_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            snap_q     <= result;
            cnt_q      <= '0;
            best_vld_q <= 1'b0;
          end
        end
        ST_SCAN: begin
          cnt_q <= cnt_q + 1'b1;
          if (take) begin
            best_q     <= elem;
            best_idx_q <= cnt_q;
            best_vld_q <= 1'b1;
          end
          // Publish on the final compare so DONE outputs are registered.
          if (last) begin
            if (take) begin
              idx_q <= cnt_q;
              max_q <= elem;
            end else if (best_vld_q) begin
              idx_q <= best_idx_q;
              max_q <= best_q;
            end else begin
              idx_q <= '0;
              max_q <= FP_CANON_NAN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign class_idx = idx_q;
  assign max_value = max_q;

endmodule

// File: tb/tb_nn_argmax_reader.sv
// Self-checking bench for nn_argmax_reader against a real-valued model.
// Define NN_ARGMAX_NAN_FLAG_EN for both bench and RTL to cover nan_seen.
module tb_nn_argmax_reader;

  localparam int N  = 10;
  localparam int IW = 4;

  logic              clk;
  logic              rst_n;
  logic [32*N-1:0]   result;
  logic              start;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [IW-1:0]     class_idx;
  logic [31:0]       max_value;
`ifdef NN_ARGMAX_NAN_FLAG_EN
  logic              nan_seen;
`endif

  int checks   = 0;
  int failures = 0;

  nn_argmax_reader #(.OUT_SIZE(N), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .result    (result),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .class_idx (class_idx),
    .max_value (max_value)
`ifdef NN_ARGMAX_NAN_FLAG_EN
    ,
    .nan_seen  (nan_seen)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 0);
  endfunction

  // Numeric value of a non-NaN float32 as a real.
  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    e = int'(f[30:23]);
    if (e == 255)    m = 1.0e300;
    else if (e == 0) m = real'(f[22:0]) * (2.0 ** (-149));
    else             m = real'({1'b1, f[22:0]}) * (2.0 ** (e - 150));
    return f[31] ? -m : m;
  endfunction

  task automatic model(input logic [32*N-1:0] v, output logic [31:0] idx,
                       output logic [31:0] val, output logic anynan);
    bit  have;
    real bv;
    logic [31:0] x;
    have = 0; bv = 0.0; anynan = 0;
    idx = 0; val = 32'h7FC00000;
    for (int i = 0; i < N; i++) begin
      x = v[32*i +: 32];
      if (is_nan(x)) anynan = 1;
      else if (!have || f2r(x) > bv) begin
        have = 1; bv = f2r(x); idx = i; val = x;
      end
    end
  endtask

  function automatic logic [31:0] rnd_elem();
    logic [31:0] pool [4];
    int r;
    pool[0] = 32'h3F800000; pool[1] = 32'hBF800000;
    pool[2] = 32'h41200000; pool[3] = 32'hC1200000;
    r = $urandom_range(0, 15);
    if (r == 0) return {$urandom_range(0, 1) == 1, 8'hFF,
                        23'($urandom_range(1, 32'h7FFFFF))};
    if (r == 1) return {$urandom_range(0, 1) == 1, 8'hFF, 23'h0};
    if (r == 2) return {$urandom_range(0, 1) == 1, 31'h0};
    if (r < 6)  return pool[$urandom_range(0, 3)];
    return {$urandom_range(0, 1) == 1, 8'($urandom_range(100, 150)),
            23'($urandom)};
  endfunction

  function automatic logic [32*N-1:0] fill(input logic [31:0] x);
    logic [32*N-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = x;
    return v;
  endfunction

  task automatic run_scan(input string tag, input logic [32*N-1:0] v,
                          input int hold);
    logic [31:0] e_idx, e_val;
    logic        e_nan;
    int          lat;
    model(v, e_idx, e_val, e_nan);
    @(negedge clk);
    result = v; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) result[32*i +: 32] = $urandom;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 20);
    chk({tag, "_latency"}, lat, N);
    chk({tag, "_idx"}, 32'(class_idx), e_idx);
    chk({tag, "_val"}, max_value, e_val);
`ifdef NN_ARGMAX_NAN_FLAG_EN
    chk({tag, "_nan"}, 32'(nan_seen), 32'(e_nan));
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_idx"}, 32'(class_idx), e_idx);
      chk({tag, "_hold_val"}, max_value, e_val);
    end
    @(negedge clk); out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ack_v"}, 32'(out_valid), 32'd0);
    @(negedge clk); out_ready = 1'b0; start = 1'b0;
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_idx"}, 32'(class_idx), e_idx);
    chk({tag, "_idle_val"}, max_value, e_val);
  endtask

  initial begin
    logic [32*N-1:0] v;
    int seen;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; result = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_idx", 32'(class_idx), 32'd0);
    chk("rst_val", max_value, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_scan("all10", fill(32'h41200000), 0);

    v = fill(32'h3F800000); v[32*7 +: 32] = 32'h42C80000;
    run_scan("max7", v, 5);

    v = fill(32'hC1200000); v[32*3 +: 32] = 32'hBF800000;
    v[31:0] = 32'h7FC00000;
    run_scan("neg3", v, 1);

    run_scan("allnan", fill(32'h7FC00000), 0);

    v = fill(32'hC0000000); v[32*2 +: 32] = 32'h80000000;
    v[32*5 +: 32] = 32'h00000000;
    run_scan("zero_tie", v, 0);

    // Reset mid-scan abandons it.
    @(negedge clk); result = fill(32'h41200000); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_idx", 32'(class_idx), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mid_rst_no_valid", seen, 0);

    v = fill(32'h3F800000); v[32*4 +: 32] = 32'h40400000;
    run_scan("after_rst", v, 0);

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N; i++) v[32*i +: 32] = rnd_elem();
      run_scan($sformatf("rand%0d", t), v, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
